// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter between instruction fetch and data access
// Data normally wins; a starvation counter forces fetch through, and a wait counter aborts hung accesses.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] pc,
  output logic [31:0] instr,
  output logic        if_valid,
  input  logic        d_req,
  input  logic        wem,
  input  logic [2:0]  rwmm,
  input  logic [31:0] rwam,
  input  logic [31:0] wdm,
  output logic [31:0] rdm,
  output logic        d_valid,
  output logic        mem_req,
  output logic        mem_we,
  output logic [2:0]  mem_mode,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        stall_if,
  output logic        stall_ma,
  output logic        bus_err
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam int WW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

  state_t         state_q, state_d;
  logic [SW-1:0]  starve_q, starve_d;
  logic [WW-1:0]  wait_q, wait_d;
  logic           mem_req_q, mem_req_d;
  logic           mem_we_q, mem_we_d;
  logic [2:0]     mem_mode_q, mem_mode_d;
  logic [31:0]    mem_addr_q, mem_addr_d;
  logic [31:0]    mem_wdata_q, mem_wdata_d;
  logic [31:0]    instr_q, instr_d;
  logic [31:0]    rdm_q, rdm_d;
  logic           if_valid_q, if_valid_d;
  logic           d_valid_q, d_valid_d;
  logic           bus_err_q, bus_err_d;
  logic           data_grant;

  assign data_grant = d_req && (!if_req || (starve_q < SW'(STARVE_LIMIT)));

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    wait_d      = wait_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_mode_d  = mem_mode_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    instr_d     = instr_q;
    rdm_d       = rdm_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    bus_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (data_grant) begin
          mem_we_d    = wem;
          mem_mode_d  = rwmm;
          mem_addr_d  = rwam;
          mem_wdata_d = wdm;
          mem_req_d   = 1'b1;
          wait_d      = '0;
          state_d     = DBUSY;
          if (if_req && (starve_q < SW'(STARVE_LIMIT))) starve_d = starve_q + SW'(1);
        end else if (if_req) begin
          mem_we_d   = 1'b0;
          mem_mode_d = 3'b010;
          mem_addr_d = pc;
          mem_req_d  = 1'b1;
          wait_d     = '0;
          starve_d   = '0;
          state_d    = IBUSY;
        end
      end
      IBUSY, DBUSY: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
          if (state_q == IBUSY) begin
            if_valid_d = 1'b1;
            instr_d    = mem_rdata;
          end else begin
            d_valid_d = 1'b1;
            if (!mem_we_q) rdm_d = mem_rdata;
          end
        end else if (wait_q == WW'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th cycle without ready: abort with a zeroed result.
          wait_d    = wait_q + WW'(1);
          mem_req_d = 1'b0;
          bus_err_d = 1'b1;
          state_d   = IDLE;
          if (state_q == IBUSY) begin
            if_valid_d = 1'b1;
            instr_d    = '0;
          end else begin
            d_valid_d = 1'b1;
            rdm_d     = '0;
          end
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      wait_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_mode_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      instr_q     <= '0;
      rdm_q       <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      wait_q      <= wait_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_mode_q  <= mem_mode_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      instr_q     <= instr_d;
      rdm_q       <= rdm_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign instr     = instr_q;
  assign rdm       = rdm_q;
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;
  assign bus_err   = bus_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_mode  = mem_mode_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign stall_if  = if_req & ~if_valid_q;
  assign stall_ma  = d_req & ~d_valid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
// Table-driven single accesses plus hand sequences; completions checked through a scoreboard queue.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] instr;
  logic        if_valid;
  logic        d_req = 1'b0;
  logic        wem = 1'b0;
  logic [2:0]  rwmm = '0;
  logic [31:0] rwam = '0;
  logic [31:0] wdm = '0;
  logic [31:0] rdm;
  logic        d_valid;
  logic        mem_req;
  logic        mem_we;
  logic [2:0]  mem_mode;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        stall_if;
  logic        stall_ma;
  logic        bus_err;

  mem_arbiter #(.STARVE_LIMIT(3), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .pc(pc), .instr(instr), .if_valid(if_valid),
    .d_req(d_req), .wem(wem), .rwmm(rwmm), .rwam(rwam), .wdm(wdm),
    .rdm(rdm), .d_valid(d_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_mode(mem_mode),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall_if(stall_if), .stall_ma(stall_ma), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fetch;
    logic [31:0] addr;
    logic        we;
    logic [2:0]  mode;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic        fetch;
    logic [31:0] data;
    logic        berr;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[7];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    while (!mem_req && n < 20) begin
      tick();
      n++;
    end
    chk("grant_seen", {31'b0, mem_req}, 32'd1);
  endtask

  always @(negedge clk) begin
    if (if_valid || d_valid || bus_err) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid if_valid=%0d d_valid=%0d bus_err=%0d required none",
                 if_valid, d_valid, bus_err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("valid_kind", {30'b0, if_valid, d_valid}, e.fetch ? 32'd2 : 32'd1);
        chk("valid_data", e.fetch ? instr : rdm, e.data);
        chk("valid_berr", {31'b0, bus_err}, {31'b0, e.berr});
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int n;
    if_req = v.fetch;
    d_req  = !v.fetch;
    pc     = v.addr;
    rwam   = v.addr;
    wem    = v.we;
    rwmm   = v.mode;
    wdm    = v.wdata;
    sb.push_back('{v.fetch, v.exp, 1'b0});
    wait_grant(n);
    chk("grant_latency", n, 1);
    if_req = 1'b0;
    d_req  = 1'b0;
    pc     = 32'hFFFF_FFF0;
    rwam   = 32'hFFFF_FFF0;
    wdm    = 32'h5555_5555;
    wem    = ~v.we;
    rwmm   = 3'b111;
    for (int c = 0; c <= v.delay; c++) begin
      chk("hold_req", {31'b0, mem_req}, 32'd1);
      chk("hold_addr", mem_addr, v.addr);
      chk("hold_we", {31'b0, mem_we}, v.fetch ? 32'd0 : {31'b0, v.we});
      chk("hold_mode", {29'b0, mem_mode}, v.fetch ? 32'd2 : {29'b0, v.mode});
      if (!v.fetch) chk("hold_wdata", mem_wdata, v.wdata);
      if (c < v.delay) tick();
    end
    mem_rdata = v.rdata;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("valid_latency", {31'b0, v.fetch ? if_valid : d_valid}, 32'd1);
    chk("req_cleared", {31'b0, mem_req}, 32'd0);
    tick();
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{1'b1, 32'h0000_0100, 1'b0, 3'b010, 32'h0,  32'h0050_0093, 0, 32'h0050_0093};
    vecs[1] = '{1'b0, 32'h0000_2000, 1'b0, 3'b010, 32'h0,  32'hDEAD_BEEF, 1, 32'hDEAD_BEEF};
    vecs[2] = '{1'b0, 32'h0000_3004, 1'b1, 3'b000, 32'hAB, 32'h9999_9999, 4, 32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 32'h0000_0104, 1'b0, 3'b010, 32'h0,  32'h1234_5678, 2, 32'h1234_5678};
    vecs[4] = '{1'b0, 32'h0000_2008, 1'b0, 3'b100, 32'h0,  32'h0000_0000, 0, 32'h0000_0000};
    vecs[5] = '{1'b0, 32'h0000_200C, 1'b0, 3'b001, 32'h0,  32'hFFFF_FFFF, 7, 32'hFFFF_FFFF};
    vecs[6] = '{1'b0, 32'h0000_2010, 1'b1, 3'b010, 32'h77, 32'h0BAD_0BAD, 0, 32'hFFFF_FFFF};

    tick();
    tick();
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_valids", {29'b0, if_valid, d_valid, bus_err}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_rdm", rdm, 32'd0);
    chk("rst_fields", mem_addr | mem_wdata | {28'b0, mem_we, mem_mode}, 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Both requesters held: three data grants, then fetch is forced, then data again.
    if_req = 1'b1; pc = 32'h500;
    d_req = 1'b1; wem = 1'b0; rwmm = 3'b010; rwam = 32'h2000;
    for (int i = 0; i < 5; i++) begin
      logic f;
      f = (i == 3);
      wait_grant(n);
      chk("conf_addr", mem_addr, f ? 32'h500 : 32'h2000);
      sb.push_back('{f, 32'hC000_0000 + i, 1'b0});
      mem_rdata = 32'hC000_0000 + i;
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      chk("conf_stall_if", {31'b0, stall_if}, {31'b0, !f});
      chk("conf_stall_ma", {31'b0, stall_ma}, {31'b0, f});
    end
    if_req = 1'b0; d_req = 1'b0;
    tick();
    chk("conf_sb_drained", sb.size(), 0);

    // Data request raised and dropped while a fetch is busy is never granted.
    if_req = 1'b1; pc = 32'h300;
    wait_grant(n);
    chk("busy_stall_if", {31'b0, stall_if}, 32'd1);
    if_req = 1'b0; d_req = 1'b1; rwam = 32'h7000;
    tick();
    d_req = 1'b0;
    sb.push_back('{1'b1, 32'h1111_2222, 1'b0});
    mem_rdata = 32'h1111_2222;
    mem_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("idle_ready_ignored", {31'b0, mem_req}, 32'd0);
    mem_ready = 1'b0;

    // Timeout on a load: eight wait cycles, then bus_err with a zeroed d_valid.
    d_req = 1'b1; wem = 1'b0; rwmm = 3'b010; rwam = 32'h4000;
    wait_grant(n);
    d_req = 1'b0;
    sb.push_back('{1'b0, 32'h0, 1'b1});
    for (int c = 0; c < 7; c++) begin
      tick();
      chk("to_pending", {31'b0, mem_req}, 32'd1);
      chk("to_no_err", {31'b0, bus_err}, 32'd0);
    end
    tick();
    chk("to_err", {31'b0, bus_err}, 32'd1);
    chk("to_dvalid", {31'b0, d_valid}, 32'd1);
    chk("to_rdm", rdm, 32'd0);
    chk("to_req_clear", {31'b0, mem_req}, 32'd0);
    tick();
    chk("to_err_pulse", {31'b0, bus_err}, 32'd0);
    chk("to_sb_drained", sb.size(), 0);

    // Reset while a load is busy: no completion, then a fresh fetch works.
    d_req = 1'b1; rwam = 32'h6000;
    wait_grant(n);
    d_req = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("rmid_req", {31'b0, mem_req}, 32'd0);
    chk("rmid_dvalid", {31'b0, d_valid}, 32'd0);
    chk("rmid_addr", mem_addr, 32'd0);
    reset = 1'b0;
    tick();
    run_vec('{1'b1, 32'h0000_0200, 1'b0, 3'b010, 32'h0, 32'h0BAD_F00D, 1, 32'h0BAD_F00D});

    tick();
    chk("final_sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 3: consecutive data grants allowed while fetch is pending before fetch is forced.
REQ-002 Parameter TIMEOUT, default 255: wait cycles without mem_ready before abort.
REQ-003 The port list SHALL be as follows; one clock; reset is synchronous and active-high.
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request
- pc  in  32  fetch address
- instr  out  32  fetched word, registered
- if_valid  out  1  one-cycle pulse: instr valid
- d_req  in  1  data access request
- wem  in  1  1 = store, 0 = load
- rwmm  in  3  access mode (width/sign), passed through
- rwam  in  32  data address
- wdm  in  32  store data
- rdm  out  32  load data, registered
- d_valid  out  1  one-cycle pulse: data access complete
- mem_req  out  1  memory request, registered
- mem_we, mem_mode, mem_addr, mem_wdata  out  1/3/32/32  latched request fields
- mem_rdata  in  32  memory read data
- mem_ready  in  1  memory completes the access this cycle
- stall_if, stall_ma  out  1  pipeline stall, combinational
- bus_err  out  1  one-cycle timeout pulse

Function
REQ-004 States: IDLE, IBUSY, DBUSY, with transitions per REQ-005 to REQ-010.
REQ-005 IDLE, d_req=1 and (if_req=0 or starve_cnt<STARVE_LIMIT): latch wem/rwmm/rwam/wdm into mem_* fields, set mem_req=1, go to DBUSY.
REQ-006 IDLE, if_req=1 and not REQ-005: latch pc into mem_addr, mem_we=0, mem_mode=3'b010, set mem_req=1, go to IBUSY.
REQ-007 In xBUSY, mem_req and all mem_* fields are held stable until mem_ready=1.
REQ-008 xBUSY with mem_ready=1: clear mem_req, pulse the matching valid for exactly one cycle, capture mem_rdata into instr (IBUSY) or rdm (DBUSY load), and return to IDLE.
REQ-009 A store completes with a d_valid pulse and rdm unchanged.
REQ-010 Minimum latency: request seen in IDLE at edge N gives mem_req=1 after N. mem_ready=1 in that cycle gives valid=1 after N+1.
REQ-011 IDLE is always visited for at least one cycle between grants.
REQ-012 starve_cnt (width clog2(STARVE_LIMIT+1)) increments, saturating, on each data grant made while if_req=1. It clears to 0 on every fetch grant.
REQ-013 Simultaneous requests: data wins unless starve_cnt==STARVE_LIMIT, in which case fetch wins.
REQ-014 wait_cnt (8 bits min) clears on entry to xBUSY and increments each xBUSY cycle with mem_ready=0.
REQ-015 When wait_cnt reaches TIMEOUT in xBUSY: bus_err=1 for one cycle, the pending valid pulses with data output 0, mem_req clears, go to IDLE.
REQ-016 stall_if = if_req & ~if_valid.
REQ-017 stall_ma = d_req & ~d_valid.
REQ-018 A request dropped before grant is ignored; no valid is issued for it.
REQ-019 A request dropped while its access is in xBUSY still completes; its valid pulse still occurs.
REQ-020 mem_ready outside xBUSY is ignored.

Reset
REQ-021 reset=1 forces IDLE; starve_cnt=0, wait_cnt=0; mem_req=0, if_valid=0, d_valid=0, bus_err=0; instr=0, rdm=0; mem_* fields=0.
REQ-022 Reset during xBUSY aborts without any valid pulse. mem_req is 0 in the cycle after the reset edge.

Verification
REQ-023 Fetch only: if_req=1, pc=0x100, mem_ready=1 on first mem_req cycle, mem_rdata=0x00500093 -> mem_addr=0x100, if_valid after 2 edges, instr=0x00500093.
REQ-024 Conflict: if_req=1 and d_req=1 load rwam=0x2000 held -> data granted 3 times (STARVE_LIMIT=3), 4th grant to fetch, starve_cnt then 0.
REQ-025 Store: d_req=1, wem=1, rwmm=3'b000, rwam=0x3004, wdm=0xAB, mem_ready delayed 4 cycles -> fields stable for 5 cycles, d_valid one pulse, rdm unchanged.
REQ-026 Timeout: TIMEOUT=8, mem_ready held 0 -> bus_err and d_valid pulse together after 8 wait cycles, rdm=0, state IDLE.
REQ-027 Reset mid-DBUSY -> no d_valid, mem_req=0 next cycle, a new fetch is granted normally afterwards.
